spi_slave_rx: RTL and testbench
===============================

Name: spi_slave_rx

Overview:
- Receive-side counterpart of the spi_final MOSI transmitter: an SPI mode-0 slave receiver running in the m_clk domain.
- Oversamples spi_sclk, spi_cs_n and spi_mosi_in, deserialises MSB-first bytes and treats the first byte of each frame as an address.
- When that address equals my_addr, the following data bytes are pushed into a 4-entry show-ahead FIFO read by local logic.
- Used at the far end of the serial link in system benches and on the target side of the design.

Parameters:
- FIFO_DEPTH, 4, data FIFO entries (power of two, ≥2).
- SYNC_STAGES, 2, synchroniser flops on each SPI input (≥2).

Ports:
- m_clk  in  1  system clock; all logic on rising edge.
- n_reset  in  1  synchronous active-low reset, sampled on m_clk rising edge.
- spi_sclk  in  1  SPI clock from master; idle low; at most m_clk/4.
- spi_cs_n  in  1  active-low frame select.
- spi_mosi_in  in  1  serial data, MSB first, stable around sclk rising edge.
- my_addr  in  8  this slave's address; compared against the first byte of each frame.
- rd_en  in  1  pop FIFO head; ignored when empty.
- data_out  out  8  FIFO head (show-ahead); 0 when empty.
- data_valid  out  1  FIFO non-empty.
- addr_match  out  1  high from address-byte acceptance until frame end.
- overrun  out  1  sticky: a byte was dropped because the FIFO was full.
- frame_err  out  1  one-cycle pulse: cs_n deasserted with a partial byte.

Behaviour:
- Reset (n_reset=0 at an m_clk edge): all outputs 0, FIFO empty, state IDLE, bit counter 0, synchronisers loaded with idle values (sclk=0, cs_n=1, mosi=0).
  - Reset overrides every other event, including mid-frame; any partial byte is lost.
- Input handling:
  - Each SPI input passes through SYNC_STAGES flops.
  - sclk_rise = synced sclk is 1 and was 0 last cycle.
  - On sclk_rise while cs_n is low: shift_reg <= {shift_reg[6:0], mosi_sync} and bit_cnt increments (3 bits, wraps 7→0).
  - A byte is complete on the sclk_rise that wraps bit_cnt to 0; shift_reg then holds the full byte.
- FSM states: IDLE, ADDR, DATA, IGNORE.
  - IDLE: synced cs_n falls → ADDR; bit_cnt cleared.
  - ADDR: byte complete → compare with my_addr. Equal: addr_match <= 1, go to DATA. Not equal: go to IGNORE.
  - DATA: each completed byte is written to the FIFO on the cycle after completion.
  - IGNORE: bytes are shifted but discarded.
  - Any state except IDLE: synced cs_n rises → IDLE and addr_match <= 0. If bit_cnt != 0, pulse frame_err for one cycle and discard the partial byte.
- Latency: data_valid rises 2 m_clk cycles after the sclk_rise detection that completes a byte (write cycle, then flag update). Add SYNC_STAGES+1 cycles from the raw sclk pin edge.
- FIFO:
  - Binary read/write pointers with an extra wrap bit.
  - full when pointers differ only in the MSB; empty when they are equal.
  - Write while full with no simultaneous pop: byte dropped, overrun <= 1, held until reset.
  - Write while full with simultaneous pop: pop and write both take effect; no overrun.
  - Pop while empty: no effect.
  - Write while empty: data_out and data_valid update together on the next cycle.
- Re-arming: a frame with 0 data bytes (cs_n rises exactly after the address byte) is legal, with no frame_err. A new cs_n fall restarts in ADDR.
- No transmit path: MISO is not implemented.

Decomposition:
- Shared package spi_pkg:
  - state encoding typedef (IDLE/ADDR/DATA/IGNORE);
  - BYTE_W=8;
  - bus idle constants.
- Sub-module spi_rx_fifo(m_clk, n_reset, wr_en, wr_data, rd_en, rd_data, empty, full), parameterised by FIFO_DEPTH, with the same synchronous active-low reset.
- Synchroniser and edge detect stay inline in spi_slave_rx.

Test Plan:
- my_addr=8'd45. Master sends 0x2D then 0x02, 0x03 with no reads → addr_match=1 during the frame. data_valid rises 2 cycles after the 16th-bit sclk_rise detection. Popping gives data_out 0x02 then 0x03, then data_valid=0.
- Address mismatch: frame 0x2C, 0x07 → addr_match stays 0, FIFO stays empty, frame_err=0.
- Overrun: frame 0x2D followed by 0x02..0x06 with no reads → FIFO holds 0x02..0x05 and overrun=1. Holding rd_en high for one cycle while 0x06 is written in place of the dropped byte stores 0x06 with no additional overrun event.
- Partial byte: cs_n rises after 5 bits of the second byte → frame_err pulses for exactly 1 cycle, nothing is written, state is IDLE, and the next frame 0x2D, 0x11 yields 0x11.
- Reset mid-frame: n_reset=0 for one edge after 3 data bits → all outputs 0 and FIFO empty. The following full frame 0x2D, 0x09 is received correctly.
- Back-to-back frames: cs_n high for 4 m_clk between frames 0x2D, 0x0A and 0x2D, 0x0B → both bytes are delivered in order with no frame_err.

Source files
------------

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_pkg
// Description : Shared types and constants for the SPI slave receiver.
//               Provides the receiver state encoding, the byte width and the
//               idle levels of the SPI bus pins.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ADDR   = 2'd1,
        ST_DATA   = 2'd2,
        ST_IGNORE = 2'd3
    } spi_state_e;

    // Levels the bus rests at between frames; synchronisers reset to these.
    localparam logic c_SCLK_IDLE = 1'b0;
    localparam logic c_CS_N_IDLE = 1'b1;
    localparam logic c_MOSI_IDLE = 1'b0;

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : spi_rx_fifo
// Description : Show-ahead byte FIFO for received SPI data.
//               Binary pointers carry one extra wrap bit to tell full from
//               empty. A write while full is accepted only when a pop
//               happens in the same cycle.
// Ports       : m_clk    - clock, rising edge
//               n_reset  - synchronous active-low reset
//               wr_en    - write request, wr_data - byte to write
//               rd_en    - pop head (ignored when empty)
//               rd_data  - head entry, 0 when empty
//               empty / full - occupancy flags
// Revision    : 1.0 - initial release
// ============================================================================
module spi_rx_fifo
    import spi_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              m_clk,
    input  logic              n_reset,
    input  logic              wr_en,
    input  logic [BYTE_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [BYTE_W-1:0] rd_data,
    output logic              empty,
    output logic              full
);

    localparam int             c_AW      = $clog2(FIFO_DEPTH);
    localparam logic [c_AW:0]  c_PTR_ONE = {{c_AW{1'b0}}, 1'b1};

    logic [c_AW:0]       r_wr_ptr;
    logic [c_AW:0]       r_rd_ptr;
    logic [BYTE_W-1:0]   r_mem [FIFO_DEPTH];

    logic                w_pop;
    logic                w_push;

    assign empty = (r_wr_ptr == r_rd_ptr);
    assign full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                   (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

    assign w_pop  = rd_en & ~empty;
    // A simultaneous pop frees the slot the write is about to use.
    assign w_push = wr_en & (~full | w_pop);

    always_ff @(posedge m_clk) begin
        if (!n_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
        end
    end

    // Storage needs no reset: rd_data is forced to 0 while empty.
    always_ff @(posedge m_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= wr_data;
        end
    end

    assign rd_data = empty ? '0 : r_mem[r_rd_ptr[c_AW-1:0]];

endmodule : spi_rx_fifo
`default_nettype wire

// File: rtl/spi_slave_rx.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_rx
// Description : SPI mode-0 slave receiver in the m_clk domain. Oversamples
//               the SPI pins, deserialises MSB-first bytes, treats the first
//               byte of a frame as an address and queues the following data
//               bytes in a show-ahead FIFO when the address matches.
// Ports       : m_clk, n_reset        - clock, synchronous active-low reset
//               spi_sclk/cs_n/mosi_in - asynchronous SPI pins
//               my_addr               - address of this slave
//               rd_en                 - pop FIFO head
//               data_out/data_valid   - FIFO head and non-empty flag
//               addr_match            - frame addressed to this slave
//               overrun               - sticky, a byte was dropped
//               frame_err             - pulse, frame ended mid-byte
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_rx
    import spi_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              m_clk,
    input  logic              n_reset,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    input  logic              spi_mosi_in,
    input  logic [BYTE_W-1:0] my_addr,
    input  logic              rd_en,
    output logic [BYTE_W-1:0] data_out,
    output logic              data_valid,
    output logic              addr_match,
    output logic              overrun,
    output logic              frame_err
);

    // ------------------------------------------------------------------
    // Input synchronisers and sclk edge detect
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sclk_prev;

    logic w_sclk_s;
    logic w_cs_n_s;
    logic w_mosi_s;
    logic w_sclk_rise;

    always_ff @(posedge m_clk) begin
        if (!n_reset) begin
            r_sclk_sync <= {SYNC_STAGES{c_SCLK_IDLE}};
            r_cs_sync   <= {SYNC_STAGES{c_CS_N_IDLE}};
            r_mosi_sync <= {SYNC_STAGES{c_MOSI_IDLE}};
            r_sclk_prev <= c_SCLK_IDLE;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0],   spi_cs_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi_in};
            r_sclk_prev <= w_sclk_s;
        end
    end

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_n_s    = r_cs_sync[SYNC_STAGES-1];
    assign w_mosi_s    = r_mosi_sync[SYNC_STAGES-1];
    assign w_sclk_rise = w_sclk_s & ~r_sclk_prev;

    // ------------------------------------------------------------------
    // Deserialiser
    // ------------------------------------------------------------------
    spi_state_e        r_state;
    spi_state_e        w_state_nxt;
    logic [BYTE_W-1:0] r_shift;
    logic [2:0]        r_bit_cnt;

    logic              w_shift_en;
    logic              w_byte_done;
    logic [BYTE_W-1:0] w_byte_full;

    assign w_shift_en  = w_sclk_rise & ~w_cs_n_s & (r_state != ST_IDLE);
    assign w_byte_done = w_shift_en & (r_bit_cnt == 3'd7);
    // The byte as it will appear in r_shift after this cycle's shift.
    assign w_byte_full = {r_shift[BYTE_W-2:0], w_mosi_s};

    always_ff @(posedge m_clk) begin
        if (!n_reset) begin
            r_shift   <= '0;
            r_bit_cnt <= 3'd0;
        end else if (r_state == ST_IDLE) begin
            r_bit_cnt <= 3'd0;
        end else if (w_shift_en) begin
            r_shift   <= w_byte_full;
            r_bit_cnt <= r_bit_cnt + 3'd1;
        end
    end

    // ------------------------------------------------------------------
    // Frame FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge m_clk) begin
        if (!n_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (!w_cs_n_s) begin
                    w_state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: begin
                if (w_cs_n_s) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_byte_done) begin
                    w_state_nxt = (w_byte_full == my_addr) ? ST_DATA : ST_IGNORE;
                end
            end
            ST_DATA, ST_IGNORE: begin
                if (w_cs_n_s) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    logic w_set_match;
    logic w_frame_end;
    logic w_frame_err;
    logic w_push_nxt;

    always_comb begin
        w_set_match = 1'b0;
        w_frame_end = 1'b0;
        w_frame_err = 1'b0;
        w_push_nxt  = 1'b0;
        if (r_state != ST_IDLE && w_cs_n_s) begin
            w_frame_end = 1'b1;
            w_frame_err = (r_bit_cnt != 3'd0);
        end
        if (r_state == ST_ADDR && w_byte_done && w_byte_full == my_addr) begin
            w_set_match = 1'b1;
        end
        if (r_state == ST_DATA && w_byte_done) begin
            w_push_nxt = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Registered outputs and FIFO
    // ------------------------------------------------------------------
    logic r_push;
    logic r_addr_match;
    logic r_frame_err;
    logic r_overrun;
    logic w_fifo_empty;
    logic w_fifo_full;

    always_ff @(posedge m_clk) begin
        if (!n_reset) begin
            r_push       <= 1'b0;
            r_addr_match <= 1'b0;
            r_frame_err  <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_push      <= w_push_nxt;
            r_frame_err <= w_frame_err;
            if (w_frame_end) begin
                r_addr_match <= 1'b0;
            end else if (w_set_match) begin
                r_addr_match <= 1'b1;
            end
            // Full FIFO always holds data, so rd_en alone means a real pop.
            if (r_push && w_fifo_full && !rd_en) begin
                r_overrun <= 1'b1;
            end
        end
    end

    spi_rx_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .m_clk   (m_clk),
        .n_reset (n_reset),
        .wr_en   (r_push),
        .wr_data (r_shift),
        .rd_en   (rd_en),
        .rd_data (data_out),
        .empty   (w_fifo_empty),
        .full    (w_fifo_full)
    );

    assign data_valid = ~w_fifo_empty;
    assign addr_match = r_addr_match;
    assign overrun    = r_overrun;
    assign frame_err  = r_frame_err;

endmodule : spi_slave_rx
`default_nettype wire

// File: tb/tb_spi_slave_rx.sv
`default_nettype none
// ============================================================================
// Module      : tb_spi_slave_rx
// Description : Self-checking bench for spi_slave_rx. A bit-banged SPI
//               master drives frames; expected FIFO contents are queued as
//               data bytes are sent and compared as they are popped.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_slave_rx;

    logic       m_clk = 1'b0;
    logic       n_reset;
    logic       spi_sclk;
    logic       spi_cs_n;
    logic       spi_mosi_in;
    logic [7:0] my_addr;
    logic       rd_en;
    logic [7:0] data_out;
    logic       data_valid;
    logic       addr_match;
    logic       overrun;
    logic       frame_err;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         fe_count = 0;
    logic [7:0] exp_q[$];
    logic       exp_ovr  = 1'b0;

    always #5 m_clk = ~m_clk;

    spi_slave_rx #(
        .FIFO_DEPTH  (4),
        .SYNC_STAGES (2)
    ) dut (
        .m_clk       (m_clk),
        .n_reset     (n_reset),
        .spi_sclk    (spi_sclk),
        .spi_cs_n    (spi_cs_n),
        .spi_mosi_in (spi_mosi_in),
        .my_addr     (my_addr),
        .rd_en       (rd_en),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .addr_match  (addr_match),
        .overrun     (overrun),
        .frame_err   (frame_err)
    );

    // Counts every cycle frame_err is high, so tests can measure pulse width.
    always @(negedge m_clk) begin
        if (frame_err === 1'b1) fe_count = fe_count + 1;
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge m_clk);
        #1;
    endtask

    // Sends the top nbits of b, MSB first; sclk runs at m_clk/8.
    task automatic spi_bits(input logic [7:0] b, input int nbits);
        for (int i = 7; i > 7 - nbits; i--) begin
            spi_mosi_in = b[i];
            tick(4);
            spi_sclk = 1'b1;
            tick(4);
            spi_sclk = 1'b0;
        end
    endtask

    // Sends a byte but leaves sclk high after the last rising edge,
    // returning 1 ns after the edge that raised the pin.
    task automatic spi_byte_open(input logic [7:0] b);
        spi_bits(b, 7);
        spi_mosi_in = b[0];
        tick(4);
        spi_sclk = 1'b1;
    endtask

    task automatic frame_start();
        spi_cs_n = 1'b0;
        tick(4);
    endtask

    task automatic frame_end();
        tick(4);
        spi_cs_n = 1'b1;
        tick(8);
    endtask

    function automatic void model_write(input logic [7:0] b);
        if (exp_q.size() < 4) exp_q.push_back(b);
        else exp_ovr = 1'b1;
    endfunction

    task automatic do_reset();
        n_reset = 1'b0; spi_cs_n = 1'b1; spi_sclk = 1'b0; spi_mosi_in = 1'b0; rd_en = 1'b0;
        tick(2);
        n_reset = 1'b1;
        exp_q.delete();
        exp_ovr = 1'b0;
        tick(2);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        n_reset = 1'b0;
        tick(2);
        @(negedge m_clk);
        n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out: got %h, expected 00", data_out); end
        n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_data_valid: got %b, expected 0", data_valid); end
        n_checks++; if (addr_match !== 1'b0) begin n_fail++; $display("FAIL reset_addr_match: got %b, expected 0", addr_match); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b, expected 0", overrun); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b, expected 0", frame_err); end
        n_reset = 1'b1;
        tick(2);
    endtask

    task automatic test_basic();
        logic [7:0] exp_b;
        frame_start();
        spi_bits(8'h2D, 8);
        tick(4);
        @(negedge m_clk);
        n_checks++; if (addr_match !== 1'b1) begin n_fail++; $display("FAIL basic_addr_match: got %b, expected 1", addr_match); end
        tick(1);
        spi_byte_open(8'h02);
        model_write(8'h02);
        tick(3);
        @(negedge m_clk);
        n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL basic_latency_early: data_valid got %b, expected 0", data_valid); end
        tick(1);
        @(negedge m_clk);
        n_checks++; if (data_valid !== 1'b1 || data_out !== 8'h02) begin n_fail++; $display("FAIL basic_latency: valid=%b data=%h, expected valid 1 data 02", data_valid, data_out); end
        tick(1);
        spi_sclk = 1'b0;
        spi_bits(8'h03, 8);
        model_write(8'h03);
        @(negedge m_clk);
        n_checks++; if (addr_match !== 1'b1) begin n_fail++; $display("FAIL basic_match_held: got %b, expected 1", addr_match); end
        frame_end();
        @(negedge m_clk);
        n_checks++; if (addr_match !== 1'b0) begin n_fail++; $display("FAIL basic_match_clear: got %b, expected 0", addr_match); end
        tick(1);
        while (exp_q.size() > 0) begin
            exp_b = exp_q.pop_front();
            rd_en = 1'b1;
            @(negedge m_clk);
            n_checks++; if (data_valid !== 1'b1 || data_out !== exp_b) begin n_fail++; $display("FAIL basic_pop: data=%h valid=%b, expected %h valid 1", data_out, data_valid, exp_b); end
            tick(1);
            rd_en = 1'b0;
        end
        @(negedge m_clk);
        n_checks++; if (data_valid !== 1'b0 || data_out !== 8'h00) begin n_fail++; $display("FAIL basic_empty: data=%h valid=%b, expected 00 valid 0", data_out, data_valid); end
        tick(1);
    endtask

    task automatic test_mismatch();
        int fe0;
        fe0 = fe_count;
        frame_start();
        spi_bits(8'h2C, 8);
        tick(4);
        @(negedge m_clk);
        n_checks++; if (addr_match !== 1'b0) begin n_fail++; $display("FAIL mismatch_addr_match: got %b, expected 0", addr_match); end
        tick(1);
        spi_bits(8'h07, 8);
        frame_end();
        @(negedge m_clk);
        n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL mismatch_fifo: data_valid got %b, expected 0", data_valid); end
        n_checks++; if (fe_count - fe0 !== 0) begin n_fail++; $display("FAIL mismatch_frame_err: pulses got %0d, expected 0", fe_count - fe0); end
        tick(1);
    endtask

    task automatic test_empty_frame();
        int fe0;
        fe0 = fe_count;
        frame_start();
        spi_bits(8'h2D, 8);
        frame_end();
        @(negedge m_clk);
        n_checks++; if (fe_count - fe0 !== 0 || addr_match !== 1'b0) begin n_fail++; $display("FAIL empty_frame: frame_err pulses %0d match %b, expected 0 and 0", fe_count - fe0, addr_match); end
        tick(1);
    endtask

    task automatic test_overrun();
        logic [7:0] exp_b;
        frame_start();
        spi_bits(8'h2D, 8);
        for (int b = 2; b <= 6; b++) begin
            spi_bits(8'(b), 8);
            model_write(8'(b));
        end
        frame_end();
        @(negedge m_clk);
        n_checks++; if (overrun !== exp_ovr) begin n_fail++; $display("FAIL overrun_flag: got %b, expected %b", overrun, exp_ovr); end
        tick(1);
        while (exp_q.size() > 0) begin
            exp_b = exp_q.pop_front();
            rd_en = 1'b1;
            @(negedge m_clk);
            n_checks++; if (data_valid !== 1'b1 || data_out !== exp_b) begin n_fail++; $display("FAIL overrun_pop: data=%h valid=%b, expected %h valid 1", data_out, data_valid, exp_b); end
            tick(1);
            rd_en = 1'b0;
        end
        @(negedge m_clk);
        n_checks++; if (data_valid !== 1'b0 || overrun !== 1'b1) begin n_fail++; $display("FAIL overrun_after_drain: valid=%b overrun=%b, expected 0 and 1", data_valid, overrun); end
        tick(1);
    endtask

    task automatic test_full_pop_write();
        logic [7:0] exp_b;
        do_reset();
        @(negedge m_clk);
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL fpw_overrun_cleared: got %b, expected 0", overrun); end
        tick(1);
        frame_start();
        spi_bits(8'h2D, 8);
        for (int b = 2; b <= 5; b++) begin
            spi_bits(8'(b), 8);
            model_write(8'(b));
        end
        spi_byte_open(8'h06);
        tick(3);
        rd_en = 1'b1;                        // high across the FIFO write edge
        @(negedge m_clk);
        exp_b = exp_q.pop_front();
        n_checks++; if (data_out !== exp_b) begin n_fail++; $display("FAIL fpw_head: got %h, expected %h", data_out, exp_b); end
        exp_q.push_back(8'h06);
        tick(1);
        rd_en = 1'b0;
        tick(3);
        spi_sclk = 1'b0;
        frame_end();
        @(negedge m_clk);
        n_checks++; if (overrun !== exp_ovr) begin n_fail++; $display("FAIL fpw_overrun: got %b, expected %b", overrun, exp_ovr); end
        tick(1);
        while (exp_q.size() > 0) begin
            exp_b = exp_q.pop_front();
            rd_en = 1'b1;
            @(negedge m_clk);
            n_checks++; if (data_valid !== 1'b1 || data_out !== exp_b) begin n_fail++; $display("FAIL fpw_pop: data=%h valid=%b, expected %h valid 1", data_out, data_valid, exp_b); end
            tick(1);
            rd_en = 1'b0;
        end
        @(negedge m_clk);
        n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL fpw_empty: data_valid got %b, expected 0", data_valid); end
        tick(1);
    endtask

    task automatic test_partial();
        logic [7:0] exp_b;
        int fe0;
        fe0 = fe_count;
        frame_start();
        spi_bits(8'h2D, 8);
        spi_bits(8'hA5, 5);
        frame_end();
        @(negedge m_clk);
        n_checks++; if (fe_count - fe0 !== 1) begin n_fail++; $display("FAIL partial_frame_err_width: got %0d cycles, expected 1", fe_count - fe0); end
        n_checks++; if (data_valid !== 1'b0 || addr_match !== 1'b0) begin n_fail++; $display("FAIL partial_nothing_written: valid=%b match=%b, expected 0 and 0", data_valid, addr_match); end
        tick(1);
        frame_start();
        spi_bits(8'h2D, 8);
        spi_bits(8'h11, 8);
        model_write(8'h11);
        frame_end();
        @(negedge m_clk);
        n_checks++; if (fe_count - fe0 !== 1) begin n_fail++; $display("FAIL partial_next_frame_err: got %0d cycles, expected 1", fe_count - fe0); end
        tick(1);
        while (exp_q.size() > 0) begin
            exp_b = exp_q.pop_front();
            rd_en = 1'b1;
            @(negedge m_clk);
            n_checks++; if (data_valid !== 1'b1 || data_out !== exp_b) begin n_fail++; $display("FAIL partial_pop: data=%h valid=%b, expected %h valid 1", data_out, data_valid, exp_b); end
            tick(1);
            rd_en = 1'b0;
        end
    endtask

    task automatic test_reset_midframe();
        logic [7:0] exp_b;
        frame_start();
        spi_bits(8'h2D, 8);
        spi_bits(8'h55, 8);
        frame_end();
        frame_start();
        spi_bits(8'h2D, 8);
        spi_bits(8'hFF, 3);
        n_reset = 1'b0; spi_cs_n = 1'b1; spi_sclk = 1'b0;
        tick(1);
        n_reset = 1'b1;
        exp_q.delete();
        exp_ovr = 1'b0;
        @(negedge m_clk);
        n_checks++; if (data_valid !== 1'b0 || data_out !== 8'h00) begin n_fail++; $display("FAIL midreset_fifo: data=%h valid=%b, expected 00 valid 0", data_out, data_valid); end
        n_checks++; if (addr_match !== 1'b0 || overrun !== 1'b0 || frame_err !== 1'b0) begin n_fail++; $display("FAIL midreset_flags: match=%b ovr=%b ferr=%b, expected 0 0 0", addr_match, overrun, frame_err); end
        tick(4);
        frame_start();
        spi_bits(8'h2D, 8);
        spi_bits(8'h09, 8);
        model_write(8'h09);
        frame_end();
        while (exp_q.size() > 0) begin
            exp_b = exp_q.pop_front();
            rd_en = 1'b1;
            @(negedge m_clk);
            n_checks++; if (data_valid !== 1'b1 || data_out !== exp_b) begin n_fail++; $display("FAIL midreset_pop: data=%h valid=%b, expected %h valid 1", data_out, data_valid, exp_b); end
            tick(1);
            rd_en = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b;
        int fe0;
        fe0 = fe_count;
        frame_start();
        spi_bits(8'h2D, 8);
        spi_bits(8'h0A, 8);
        model_write(8'h0A);
        tick(4);
        spi_cs_n = 1'b1;
        tick(4);
        frame_start();
        spi_bits(8'h2D, 8);
        spi_bits(8'h0B, 8);
        model_write(8'h0B);
        frame_end();
        @(negedge m_clk);
        n_checks++; if (fe_count - fe0 !== 0) begin n_fail++; $display("FAIL b2b_frame_err: pulses got %0d, expected 0", fe_count - fe0); end
        tick(1);
        while (exp_q.size() > 0) begin
            exp_b = exp_q.pop_front();
            rd_en = 1'b1;
            @(negedge m_clk);
            n_checks++; if (data_valid !== 1'b1 || data_out !== exp_b) begin n_fail++; $display("FAIL b2b_pop: data=%h valid=%b, expected %h valid 1", data_out, data_valid, exp_b); end
            tick(1);
            rd_en = 1'b0;
        end
        @(negedge m_clk);
        n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: data_valid got %b, expected 0", data_valid); end
    endtask

    initial begin
        n_reset     = 1'b0;
        spi_sclk    = 1'b0;
        spi_cs_n    = 1'b1;
        spi_mosi_in = 1'b0;
        rd_en       = 1'b0;
        my_addr     = 8'd45;
        test_reset();
        test_basic();
        test_mismatch();
        test_empty_frame();
        test_overrun();
        test_full_pop_write();
        test_partial();
        test_reset_midframe();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_spi_slave_rx
`default_nettype wire
